// File: rtl/regfile_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | regfile_pkg : shared register-file write types and constants     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package regfile_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int REG_DATA_W = 32;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;
   typedef logic [REG_DATA_W-1:0] reg_data_t;

   typedef struct packed {
      reg_addr_t rd;
      reg_data_t data;
   } wr_req_t;

   localparam reg_addr_t REG_ZERO = '0;

endpackage
`default_nettype wire

// File: rtl/wr_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | wr_fifo : sync FIFO of pending writes with per-entry rd match    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module wr_fifo
   import regfile_pkg::*;
#(
   parameter int  DEPTH = 4,
   parameter int  AW    = REG_ADDR_W,
   parameter type REQ_T = wr_req_t
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_i,
   input  REQ_T                     push_req_i,
   input  logic                     pop_i,
   input  logic [AW-1:0]            query_rd_i,
   output REQ_T                     head_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     empty_o,
   output logic [DEPTH-1:0]         match_o
);

   localparam int            PW       = $clog2(DEPTH);
   localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
   localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);
   localparam logic [PW-1:0] PTR_ONE  = PW'(1);

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW:0]   count_q, count_d;
   REQ_T          mem_q [DEPTH];
   REQ_T          mem_d [DEPTH];
   logic          w_push;
   logic          w_pop;
   logic          w_full;

   assign w_full  = (count_q == CNT_FULL);
   assign empty_o = (count_q == '0);
   assign w_push  = push_i & ~w_full;
   assign w_pop   = pop_i & ~empty_o;
   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (w_push) begin
         mem_d[wr_ptr_q] = push_req_i;
         wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end
      if (w_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      case ({w_push, w_pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: an empty count makes every slot invisible.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   for (genvar i = 0; i < DEPTH; i++) begin : g_match
      logic [PW-1:0] w_off;
      assign w_off      = PW'(i) - rd_ptr_q;
      assign match_o[i] = ({1'b0, w_off} < count_q) && (mem_q[i].rd == query_rd_i);
   end

endmodule
`default_nettype wire

// File: rtl/reg_write_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | reg_write_arbiter : merges pipeline writeback and multi-cycle    |
// | results onto the single register-file write port. Rev 1.0       |
// +------------------------------------------------------------------+
module reg_write_arbiter
   import regfile_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 5,
   parameter int DATA_WIDTH    = 32,
   parameter int DEPTH         = 4,
   parameter int STARVE_LIMIT  = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wb_valid_i,
   input  logic [ADDRESS_WIDTH-1:0] wb_rd_i,
   input  logic [DATA_WIDTH-1:0]    wb_data_i,
   input  logic                     mc_valid_i,
   output logic                     mc_ready_o,
   input  logic [ADDRESS_WIDTH-1:0] mc_rd_i,
   input  logic [DATA_WIDTH-1:0]    mc_data_i,
   input  logic [ADDRESS_WIDTH-1:0] query_rd_i,
   output logic                     query_hit_o,
   output logic                     stall_o,
   output logic                     error_o,
   output logic [ADDRESS_WIDTH-1:0] AD3_o,
   output logic                     WE3_o,
   output logic [DATA_WIDTH-1:0]    WD3_o
);

   localparam int                   CW         = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0]        FIFO_FULL  = CW'(DEPTH);
   localparam int                   SW         = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0]        STARVE_MAX = SW'(STARVE_LIMIT);
   localparam logic [SW-1:0]        STARVE_ONE = SW'(1);
   localparam logic [ADDRESS_WIDTH-1:0] RD_ZERO = ADDRESS_WIDTH'(REG_ZERO);

   typedef struct packed {
      logic [ADDRESS_WIDTH-1:0] rd;
      logic [DATA_WIDTH-1:0]    data;
   } req_t;

   req_t                     w_push_req;
   req_t                     w_head;
   logic [CW-1:0]            w_fifo_count;
   logic                     w_fifo_empty;
   logic [DEPTH-1:0]         w_match;
   logic                     w_push;
   logic                     w_pop;

   logic [ADDRESS_WIDTH-1:0] ad3_q, ad3_d;
   logic                     we3_q, we3_d;
   logic [DATA_WIDTH-1:0]    wd3_q, wd3_d;
   logic [SW-1:0]            starve_q, starve_d;
   logic                     stall_q, stall_d;
   logic                     error_q, error_d;

   assign w_push_req = '{rd: mc_rd_i, data: mc_data_i};
   assign mc_ready_o = (w_fifo_count != FIFO_FULL);
   assign w_push     = mc_valid_i & mc_ready_o;
   assign w_pop      = ~wb_valid_i & ~w_fifo_empty;

   wr_fifo #(
      .DEPTH (DEPTH),
      .AW    (ADDRESS_WIDTH),
      .REQ_T (req_t)
   ) u_wr_fifo (
      .clk        (clk),
      .rst        (rst),
      .push_i     (w_push),
      .push_req_i (w_push_req),
      .pop_i      (w_pop),
      .query_rd_i (query_rd_i),
      .head_o     (w_head),
      .count_o    (w_fifo_count),
      .empty_o    (w_fifo_empty),
      .match_o    (w_match)
   );

   always_comb begin
      ad3_d    = ad3_q;
      wd3_d    = wd3_q;
      we3_d    = 1'b0;
      starve_d = starve_q;
      if (wb_valid_i) begin
         ad3_d = wb_rd_i;
         wd3_d = wb_data_i;
         we3_d = (wb_rd_i != RD_ZERO);
      end else if (!w_fifo_empty) begin
         ad3_d = w_head.rd;
         wd3_d = w_head.data;
         we3_d = (w_head.rd != RD_ZERO);
      end
      // Counts consecutive cycles the queued head loses to writeback.
      if (w_fifo_empty || w_pop) begin
         starve_d = '0;
      end else if (wb_valid_i && (starve_q != STARVE_MAX)) begin
         starve_d = starve_q + STARVE_ONE;
      end
      stall_d = (starve_d == STARVE_MAX);
      error_d = error_q | (wb_valid_i & stall_q);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ad3_q    <= '0;
         we3_q    <= 1'b0;
         wd3_q    <= '0;
         starve_q <= '0;
         stall_q  <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         ad3_q    <= ad3_d;
         we3_q    <= we3_d;
         wd3_q    <= wd3_d;
         starve_q <= starve_d;
         stall_q  <= stall_d;
         error_q  <= error_d;
      end
   end

   assign query_hit_o = (query_rd_i != RD_ZERO) &&
                        ((|w_match) || (we3_q && (ad3_q == query_rd_i)));

   assign AD3_o   = ad3_q;
   assign WE3_o   = we3_q;
   assign WD3_o   = wd3_q;
   assign stall_o = stall_q;
   assign error_o = error_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_write_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_reg_write_arbiter : directed + random bench with queue model  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_reg_write_arbiter;

   localparam int DEPTH        = 4;
   localparam int STARVE_LIMIT = 3;

   logic        clk;
   logic        rst;
   logic        wb_valid_i;
   logic [4:0]  wb_rd_i;
   logic [31:0] wb_data_i;
   logic        mc_valid_i;
   logic        mc_ready_o;
   logic [4:0]  mc_rd_i;
   logic [31:0] mc_data_i;
   logic [4:0]  query_rd_i;
   logic        query_hit_o;
   logic        stall_o;
   logic        error_o;
   logic [4:0]  AD3_o;
   logic        WE3_o;
   logic [31:0] WD3_o;

   reg_write_arbiter #(
      .ADDRESS_WIDTH (5),
      .DATA_WIDTH    (32),
      .DEPTH         (DEPTH),
      .STARVE_LIMIT  (STARVE_LIMIT)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .wb_valid_i  (wb_valid_i),
      .wb_rd_i     (wb_rd_i),
      .wb_data_i   (wb_data_i),
      .mc_valid_i  (mc_valid_i),
      .mc_ready_o  (mc_ready_o),
      .mc_rd_i     (mc_rd_i),
      .mc_data_i   (mc_data_i),
      .query_rd_i  (query_rd_i),
      .query_hit_o (query_hit_o),
      .stall_o     (stall_o),
      .error_o     (error_o),
      .AD3_o       (AD3_o),
      .WE3_o       (WE3_o),
      .WD3_o       (WD3_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } ent_t;

   ent_t        m_q[$];
   bit          m_we;
   logic [4:0]  m_ad;
   logic [31:0] m_wd;
   int          m_run;
   bit          m_stall;
   bit          m_err;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_we    = 1'b0;
      m_ad    = '0;
      m_wd    = '0;
      m_run   = 0;
      m_stall = 1'b0;
      m_err   = 1'b0;
   endtask

   // One cycle: drive after the falling edge, compare, advance the model, wait.
   task automatic step(input bit wbv, input logic [4:0] wrd, input logic [31:0] wdat,
                       input bit mcv, input logic [4:0] mrd, input logic [31:0] mdat,
                       input logic [4:0] qrd);
      bit   exp_hit;
      bit   do_push;
      bit   blocked;
      ent_t e;
      wb_valid_i = wbv;
      wb_rd_i    = wrd;
      wb_data_i  = wdat;
      mc_valid_i = mcv;
      mc_rd_i    = mrd;
      mc_data_i  = mdat;
      query_rd_i = qrd;
      #1;
      exp_hit = 1'b0;
      if (qrd != 5'd0) begin
         if (m_we && (m_ad == qrd)) exp_hit = 1'b1;
         foreach (m_q[i]) if (m_q[i].rd == qrd) exp_hit = 1'b1;
      end
      check_eq("we3", 64'(WE3_o), 64'(m_we));
      if (m_we) begin
         check_eq("ad3", 64'(AD3_o), 64'(m_ad));
         check_eq("wd3", 64'(WD3_o), 64'(m_wd));
      end
      check_eq("mc_ready", 64'(mc_ready_o), 64'(m_q.size() < DEPTH));
      check_eq("stall", 64'(stall_o), 64'(m_stall));
      check_eq("error", 64'(error_o), 64'(m_err));
      check_eq("query_hit", 64'(query_hit_o), 64'(exp_hit));

      do_push = mcv && (m_q.size() < DEPTH);
      blocked = (m_q.size() > 0) && wbv;
      if (wbv && m_stall) m_err = 1'b1;
      if (wbv) begin
         m_we = (wrd != 5'd0);
         m_ad = wrd;
         m_wd = wdat;
      end else if (m_q.size() > 0) begin
         e    = m_q.pop_front();
         m_we = (e.rd != 5'd0);
         m_ad = e.rd;
         m_wd = e.data;
      end else begin
         m_we = 1'b0;
      end
      m_run   = blocked ? m_run + 1 : 0;
      m_stall = (m_run >= STARVE_LIMIT);
      if (do_push) m_q.push_back('{rd: mrd, data: mdat});
      @(negedge clk);
   endtask

   task automatic idle(input int n, input logic [4:0] qrd);
      for (int i = 0; i < n; i++) step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, qrd);
   endtask

   initial begin
      rst        = 1'b1;
      wb_valid_i = 1'b0;
      wb_rd_i    = '0;
      wb_data_i  = '0;
      mc_valid_i = 1'b0;
      mc_rd_i    = '0;
      mc_data_i  = '0;
      query_rd_i = '0;
      model_reset();
      repeat (2) @(negedge clk);
      check_eq("rst_we3", 64'(WE3_o), 64'(0));
      check_eq("rst_ad3", 64'(AD3_o), 64'(0));
      check_eq("rst_wd3", 64'(WD3_o), 64'(0));
      check_eq("rst_ready", 64'(mc_ready_o), 64'(1));
      check_eq("rst_stall", 64'(stall_o), 64'(0));
      check_eq("rst_error", 64'(error_o), 64'(0));
      rst = 1'b0;

      // wb only
      step(1, 5'd10, 32'h1234, 0, 5'd0, 32'd0, 5'd10);
      idle(2, 5'd10);

      // fill to full while writeback occupies the port, then drain
      for (int i = 1; i <= 4; i++)
         step(1, 5'(16 + i), 32'(i), 1, 5'(i), 32'(8'hA0 + i), 5'd3);
      step(0, 5'd0, 32'd0, 1, 5'd9, 32'h99, 5'd4);
      idle(6, 5'd4);

      // x0 suppression
      step(0, 5'd0, 32'd0, 1, 5'd0, 32'hFFFF_FFFF, 5'd0);
      idle(3, 5'd0);

      // hazard lookup on a queued entry
      step(1, 5'd9, 32'h9, 1, 5'd5, 32'h55, 5'd5);
      step(1, 5'd9, 32'h9, 0, 5'd0, 32'd0, 5'd5);
      idle(4, 5'd5);

      // priority, starvation and contract violation
      step(0, 5'd0, 32'd0, 1, 5'd7, 32'h77, 5'd7);
      step(1, 5'd1, 32'h11, 1, 5'd8, 32'h88, 5'd7);
      for (int i = 0; i < 5; i++) step(1, 5'(11 + i), 32'(i), 0, 5'd0, 32'd0, 5'd7);
      idle(4, 5'd7);

      // async reset mid-drain
      for (int i = 1; i <= 3; i++)
         step(1, 5'd20, 32'h20, 1, 5'(i), 32'(i), 5'd2);
      step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd2);
      #2 rst = 1'b1;
      #1;
      model_reset();
      check_eq("arst_we3", 64'(WE3_o), 64'(0));
      check_eq("arst_ready", 64'(mc_ready_o), 64'(1));
      check_eq("arst_hit", 64'(query_hit_o), 64'(0));
      check_eq("arst_error", 64'(error_o), 64'(0));
      @(negedge clk);
      rst = 1'b0;
      idle(4, 5'd3);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         bit wbv;
         if (m_stall) wbv = ($urandom_range(0, 15) == 0);
         else         wbv = ($urandom_range(0, 2) != 0);
         step(wbv, 5'($urandom_range(0, 7)), $urandom,
              ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)), $urandom,
              5'($urandom_range(0, 7)));
      end
      idle(8, 5'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
